// File: rtl/sram_port_arbiter_if.sv
// CPU-side bus between the inst/data SRAM master ports and the shared-SRAM arbiter.
//   inst_*  : fetch request (req/addr) and response (addr_ok/data_ok/rdata)
//   data_*  : load/store request (req/wr/wstrb/addr/wdata) and response
// Modports:
//   master : CPU side, drives requests and receives handshakes and read data
//   slave  : arbiter side, receives requests and drives handshakes and read data
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the CPU fetch and load/store ports.
// One access is granted per cycle (data first, fetch forced after MAX_DATA_STREAK data grants
// while a fetch waits); the response one cycle later is steered back to the granted master.
// Ports:
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   bus        : CPU-side req/addr_ok/data_ok bus (slave modport)
//   mem_en     : SRAM enable
//   mem_wen    : SRAM byte write enables (all zero = read)
//   mem_addr   : SRAM byte address
//   mem_wdata  : SRAM write data
//   mem_rdata  : SRAM read data, valid the cycle after a read access
module sram_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_port_arbiter_if.slave    bus,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    RespNone,
    RespInst,
    RespDataRd,
    RespDataWr
  } resp_e;

  resp_e               resp_src_q, resp_src_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                inst_starved;
  logic                data_gnt;
  logic                inst_gnt;

  // Grant: data wins unless a waiting fetch has already lost MAX_DATA_STREAK times in a row.
  // Grants are suppressed while reset is asserted so no handshake leaks out of reset.
  always_comb begin
    inst_starved = bus.inst_req && (streak_q == StreakMax);
    data_gnt     = !rst && bus.data_req && !inst_starved;
    inst_gnt     = !rst && bus.inst_req && !data_gnt;
  end

  always_comb begin
    bus.inst_addr_ok = inst_gnt;
    bus.data_addr_ok = data_gnt;
    mem_en           = data_gnt || inst_gnt;
    mem_wen          = (data_gnt && bus.data_wr) ? bus.data_wstrb : '0;
    mem_wdata        = bus.data_wdata;
    if (data_gnt) begin
      mem_addr = bus.data_addr;
    end else if (inst_gnt) begin
      mem_addr = bus.inst_addr;
    end else begin
      mem_addr = '0;
    end
  end

  // Next state: the response source simply records this cycle's grant, so the
  // arbiter accepts a new request every cycle.
  always_comb begin
    resp_src_d = RespNone;
    if (data_gnt) begin
      resp_src_d = bus.data_wr ? RespDataWr : RespDataRd;
    end else if (inst_gnt) begin
      resp_src_d = RespInst;
    end

    streak_d = '0;
    if (data_gnt && bus.inst_req) begin
      streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_src_q <= RespNone;
      streak_q   <= '0;
    end else begin
      resp_src_q <= resp_src_d;
      streak_q   <= streak_d;
    end
  end

  // Response steering: read data passes straight from the SRAM in the response cycle;
  // rdata outputs are held at zero whenever their data_ok is low.
  always_comb begin
    bus.inst_data_ok = (resp_src_q == RespInst);
    bus.data_data_ok = (resp_src_q == RespDataRd) || (resp_src_q == RespDataWr);
    bus.inst_rdata   = (resp_src_q == RespInst) ? mem_rdata : '0;
    bus.data_rdata   = (resp_src_q == RespDataRd) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int unsigned MaxStreak = 4;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_port_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_DATA_STREAK (MaxStreak)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] key);
    return {key[15:0], ~key[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // SRAM behavioural model: synchronous, write-first-at-edge, one-cycle read latency.
  logic [31:0] sram [logic [31:0]];
  logic        pl_valid = 1'b0;
  logic [31:0] pl_addr  = '0;
  logic [31:0] pl_data  = '0;

  always @(posedge clk) begin
    logic [31:0] key;
    logic [31:0] cur;
    if (pl_valid) sram[pl_addr >> 2] = pl_data;
    if (mem_en) begin
      key = mem_addr >> 2;
      cur = sram.exists(key) ? sram[key] : init_word(key);
      if (mem_wen != 4'b0) sram[key] = merge(cur, mem_wdata, mem_wen);
      else mem_rdata <= cur;
    end
  end

  // Reference model: arbitration rules, expected memory contents, one pending response.
  logic [31:0] ref_mem [logic [31:0]];
  int          m_streak = 0;
  int          m_resp   = 0;       // 0 none, 1 inst, 2 load, 3 store
  logic [31:0] m_rdata  = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] key;
    key = addr >> 2;
    return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
  endfunction

  logic        obs_iaok, obs_daok, obs_idok, obs_ddok;
  logic [31:0] obs_irdata, obs_drdata;

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    ref_mem[addr >> 2] = val;
    pl_addr  = addr;
    pl_data  = val;
    pl_valid = 1'b1;
    @(posedge clk);
    #1 pl_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_resp   = 0;
    m_rdata  = '0;
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model.
  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                      input logic dwr, input logic [3:0] dstrb, input logic [31:0] daddr,
                      input logic [31:0] dwdata);
    logic exp_d, exp_i;
    @(negedge clk);
    bus.inst_req   = ireq;
    bus.inst_addr  = iaddr;
    bus.data_req   = dreq;
    bus.data_wr    = dwr;
    bus.data_wstrb = dstrb;
    bus.data_addr  = daddr;
    bus.data_wdata = dwdata;
    #1;
    exp_d = dreq && !(ireq && m_streak == MaxStreak);
    exp_i = ireq && !exp_d;
    obs_iaok   = bus.inst_addr_ok;
    obs_daok   = bus.data_addr_ok;
    obs_idok   = bus.inst_data_ok;
    obs_ddok   = bus.data_data_ok;
    obs_irdata = bus.inst_rdata;
    obs_drdata = bus.data_rdata;
    check("inst_addr_ok", {31'b0, obs_iaok}, {31'b0, exp_i});
    check("data_addr_ok", {31'b0, obs_daok}, {31'b0, exp_d});
    check("mem_en", {31'b0, mem_en}, {31'b0, exp_d | exp_i});
    check("mem_wen", {28'b0, mem_wen}, {28'b0, (exp_d && dwr) ? dstrb : 4'b0});
    if (exp_d) check("mem_addr_d", mem_addr, daddr);
    if (exp_i) check("mem_addr_i", mem_addr, iaddr);
    if (exp_d && dwr) check("mem_wdata", mem_wdata, dwdata);
    check("inst_data_ok", {31'b0, obs_idok}, {31'b0, m_resp == 1});
    check("inst_rdata", obs_irdata, (m_resp == 1) ? m_rdata : 32'h0);
    check("data_data_ok", {31'b0, obs_ddok}, {31'b0, m_resp >= 2});
    check("data_rdata", obs_drdata, (m_resp == 2) ? m_rdata : 32'h0);
    if (exp_d) begin
      if (dwr) begin
        ref_mem[daddr >> 2] = merge(ref_read(daddr), dwdata, dstrb);
        m_resp = 3;
      end else begin
        m_rdata = ref_read(daddr);
        m_resp  = 2;
      end
      m_streak = ireq ? ((m_streak < MaxStreak) ? m_streak + 1 : MaxStreak) : 0;
    end else if (exp_i) begin
      m_rdata  = ref_read(iaddr);
      m_resp   = 1;
      m_streak = 0;
    end else begin
      m_resp   = 0;
      m_streak = 0;
    end
  endtask

  task automatic step_idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iaok"}, {31'b0, bus.inst_addr_ok}, 32'h0);
    check({tag, "_daok"}, {31'b0, bus.data_addr_ok}, 32'h0);
    check({tag, "_idok"}, {31'b0, bus.inst_data_ok}, 32'h0);
    check({tag, "_ddok"}, {31'b0, bus.data_data_ok}, 32'h0);
    check({tag, "_irdata"}, bus.inst_rdata, 32'h0);
    check({tag, "_drdata"}, bus.data_rdata, 32'h0);
    check({tag, "_mem_en"}, {31'b0, mem_en}, 32'h0);
    check({tag, "_mem_wen"}, {28'b0, mem_wen}, 32'h0);
  endtask

  initial begin
    logic [5:0]  seq;
    logic [31:0] ra, da;
    rst = 1'b1;
    idle_inputs();
    model_reset();

    // 1: reset held, preload test data, then release with no requests.
    preload(32'hBFC0_0000, 32'h3C1D_0001);
    preload(32'h0000_0200, 32'h1122_3344);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    repeat (3) step_idle();

    // 2: single fetch.
    step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t2_addr_ok", {31'b0, obs_iaok}, 32'h1);
    step_idle();
    check("t2_data_ok", {31'b0, obs_idok}, 32'h1);
    check("t2_rdata", obs_irdata, 32'h3C1D_0001);

    // 3: simultaneous fetch and load: data first, then fetch.
    step(1'b1, 32'hBFC0_0000, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
    check("t3_data_first", {30'b0, obs_daok, obs_iaok}, 32'h2);
    step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t3_inst_second", {30'b0, obs_daok, obs_iaok}, 32'h1);
    check("t3_data_ok", {31'b0, obs_ddok}, 32'h1);
    step_idle();
    check("t3_inst_ok", {31'b0, obs_idok}, 32'h1);
    check("t3_inst_rdata", obs_irdata, 32'h3C1D_0001);

    // 4: both held -> D,D,D,D,I,D with the streak cleared by the fetch.
    step_idle();
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h0000_0300, 1'b1, 1'b0, 4'h0, 32'h0000_0304, 32'h0);
      seq = {seq[4:0], obs_daok};
    end
    check("t4_grant_order", {26'b0, seq}, {26'b0, 6'b111101});
    step_idle();

    // 5: partial store then load of the same word on the next cycle.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'hAABB_CCDD);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
    check("t5_store_ok", {31'b0, obs_ddok}, 32'h1);
    check("t5_store_rdata", obs_drdata, 32'h0);
    step_idle();
    check("t5_load_ok", {31'b0, obs_ddok}, 32'h1);
    check("t5_load_rdata", obs_drdata, 32'h1122_CCDD);

    // Store with no byte enables still completes.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h0000_0200, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
    check("wstrb0_ok", {31'b0, obs_ddok}, 32'h1);
    step_idle();
    check("wstrb0_rdata", obs_drdata, 32'h1122_CCDD);

    // 6: reset right after a fetch is accepted discards its response.
    step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t6_addr_ok", {31'b0, obs_iaok}, 32'h1);
    #1;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1 check_reset_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    step_idle();
    check("t6_no_data_ok", {31'b0, obs_idok}, 32'h0);
    step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step_idle();
    check("t6_after_ok", {31'b0, obs_idok}, 32'h1);
    check("t6_after_rdata", obs_irdata, 32'h3C1D_0001);

    // Random traffic over a small address window to provoke hazards and starvation.
    for (int n = 0; n < 2000; n++) begin
      ra = 32'h0000_0200 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      da = 32'h0000_0200 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      step(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 4'($urandom), da, $urandom);
    end
    step_idle();
    step_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
